// File: rtl/fetch_unit.sv
// RV32I instruction fetch: credit-based imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds a saturating bubble counter output.
module fetch_unit #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall_d,
  output logic             valid_d,
  output logic [WIDTH-1:0] ins_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WIDTH-1:0] bubble_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] pc;
  } fq_entry_t;

  fq_entry_t        fq_mem [DEPTH];
  logic [WIDTH-1:0] tag_q  [DEPTH];

  logic [WIDTH-1:0] fetch_pc;
  logic [AW-1:0]    rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]    count, inflight, drop;
  logic [CW:0]      credit_sum;
  logic             credit, accept, pop, fq_wr;

  assign credit_sum = {1'b0, inflight} + {1'b0, count};
  assign credit     = credit_sum < (CW+1)'(DEPTH);
  // Gated by rst_n so nothing is requested while the core is held in reset.
  assign imem_req   = rst_n && !redirect && credit;
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_ready;

  assign valid_d    = (count != '0);
  assign pop        = valid_d && !stall_d && !redirect;
  assign fq_wr      = imem_rvalid && (drop == '0) && !redirect;

  assign ins_d      = valid_d ? fq_mem[rd_ptr].ins : NOP;
  // With nothing buffered, show the next fetch address.
  assign pc_d       = valid_d ? fq_mem[rd_ptr].pc : fetch_pc;
  assign pc_plus4_d = pc_d + WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      // Tags pop on every return, stale or not, so the queue stays aligned with memory.
      if (accept)      tag_wr <= tag_wr + AW'(1);
      if (imem_rvalid) tag_rd <= tag_rd + AW'(1);
      inflight <= inflight + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= wr_ptr;
        count    <= '0;
        drop     <= inflight - CW'(imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + WIDTH'(4);
        if (fq_wr)  wr_ptr   <= wr_ptr + AW'(1);
        if (pop)    rd_ptr   <= rd_ptr + AW'(1);
        count <= count + CW'(fq_wr) - CW'(pop);
        if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr]  <= fetch_pc;
    if (fq_wr)  fq_mem[wr_ptr] <= '{ins: imem_rdata, pc: tag_q[tag_rd]};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          bubble_cnt <= '0;
    else if (!valid_d && bubble_cnt != '1) bubble_cnt <= bubble_cnt + WIDTH'(1);
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences, random stream vs. model.
module tb_fetch_unit;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk, rst_n;
  logic imem_req, imem_ready, imem_rvalid, redirect, stall_d, valid_d;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, ins_d, pc_d, pc_plus4_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  fetch_unit #(.WIDTH(32), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall_d(stall_d),
    .valid_d(valid_d), .ins_d(ins_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d)
`ifdef FETCH_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad, cyc, pops, lat_min, lat_max;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  logic [31:0] exp_addr, exp_next;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_ins, s_pc4, s_bub;

  typedef struct {
    logic st, rdy, rd;
    logic ereq; logic [31:0] eaddr; logic evld; logic [31:0] epc;
  } vec_t;
  vec_t tbl[24];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, sample, update model, wait for next negedge.
  task automatic step(input logic st, input logic rdy, input logic rd, input logic [31:0] rpc);
    stall_d = st; imem_ready = rdy; redirect = rd; redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = valid_d;
    s_pc = pc_d; s_ins = ins_d; s_pc4 = pc_plus4_d;
`ifdef FETCH_PERF_CNT_EN
    s_bub = bubble_cnt;
`else
    s_bub = 32'h0;
`endif
    if (rd) chk("req_on_redirect", 32'(s_req), 32'h0);
    if (!s_valid) chk("nop_when_empty", s_ins, NOP);
    if (s_valid) chk("pc_plus4", s_pc4, s_pc + 32'd4);
    if (s_req) chk("fetch_addr", s_addr, exp_addr);
    if (s_valid && !st && !rd) begin
      chk("stream_pc", s_pc, exp_next);
      chk("stream_ins", s_ins, mem_word(s_pc));
      exp_next += 32'd4;
      pops++;
    end
    if (imem_rvalid) void'(mq.pop_front());
    if (rd) begin
      exp_next = rpc; exp_addr = rpc;
    end else if (s_req && rdy) begin
      mq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      exp_addr += 32'd4;
      chk("credit", 32'(mq.size() <= D), 32'h1);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; pops = 0; lat_min = 1; lat_max = 1;
    exp_addr = RPC; exp_next = RPC;
    rst_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall_d = 1'b0;

    #23;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(valid_d), 32'h0);
    chk("rst_ins", ins_d, NOP);
    chk("rst_pc", pc_d, RPC);
    chk("rst_pc4", pc_plus4_d, RPC + 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_bubble", bubble_cnt, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    //          st rdy rd  req addr     vld pc
    tbl[0]  = '{0, 1, 0,  1, 32'd0,    0, 32'd0};
    tbl[1]  = '{0, 1, 0,  1, 32'd4,    0, 32'd0};
    tbl[2]  = '{0, 1, 0,  1, 32'd8,    1, 32'd0};
    tbl[3]  = '{0, 1, 0,  1, 32'd12,   1, 32'd4};
    tbl[4]  = '{1, 1, 0,  1, 32'd16,   1, 32'd8};
    tbl[5]  = '{1, 1, 0,  1, 32'd20,   1, 32'd8};
    tbl[6]  = '{1, 1, 0,  0, 32'd24,   1, 32'd8};
    tbl[7]  = '{1, 1, 0,  0, 32'd24,   1, 32'd8};
    tbl[8]  = '{1, 1, 0,  0, 32'd24,   1, 32'd8};
    tbl[9]  = '{1, 1, 0,  0, 32'd24,   1, 32'd8};
    tbl[10] = '{0, 1, 0,  0, 32'd24,   1, 32'd8};
    tbl[11] = '{0, 1, 0,  1, 32'd24,   1, 32'd12};
    tbl[12] = '{0, 1, 0,  1, 32'd28,   1, 32'd16};
    tbl[13] = '{0, 1, 0,  1, 32'd32,   1, 32'd20};
    tbl[14] = '{0, 0, 0,  1, 32'd36,   1, 32'd24};
    tbl[15] = '{0, 1, 0,  1, 32'd36,   1, 32'd28};
    tbl[16] = '{0, 0, 0,  1, 32'd40,   1, 32'd32};
    tbl[17] = '{0, 1, 0,  1, 32'd40,   1, 32'd36};
    tbl[18] = '{0, 1, 0,  1, 32'd44,   0, 32'd0};
    tbl[19] = '{0, 1, 0,  1, 32'd48,   1, 32'd40};
    tbl[20] = '{0, 1, 1,  0, 32'd52,   1, 32'd44};
    tbl[21] = '{0, 1, 0,  1, 32'h100,  0, 32'd0};
    tbl[22] = '{0, 1, 0,  1, 32'h104,  0, 32'd0};
    tbl[23] = '{0, 1, 0,  1, 32'h108,  1, 32'h100};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].st, tbl[i].rdy, tbl[i].rd, 32'h100);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].ereq));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].evld));
      if (tbl[i].evld) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
`ifdef FETCH_PERF_CNT_EN
      if (i == 2)  chk("bubble_first_valid", s_bub, 32'd2);
      if (i == 23) chk("bubble_after_redirect", s_bub, 32'd5);
`endif
    end

    // Redirect with two requests outstanding, the older one returning that cycle.
    begin
      bit found, seen;
      lat_min = 2; lat_max = 2; found = 0; seen = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (mq.size() == 2 && mq[0].due <= cyc) found = 1;
        else step(0, 1, 0, 32'h0);
      end
      chk("seqA_setup", 32'(found), 32'h1);
      step(0, 1, 1, 32'h100);
      for (int i = 0; i < 20 && !seen; i++) begin
        step(0, 1, 0, 32'h0);
        if (s_valid) begin
          seen = 1;
          chk("seqA_pc", s_pc, 32'h100);
          chk("seqA_ins", s_ins, mem_word(32'h100));
        end
      end
      chk("seqA_seen", 32'(seen), 32'h1);
    end

    // Redirect while decode is stalled and the FIFO is full.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0);
    chk("seqB_full_req", 32'(s_req), 32'h0);
    chk("seqB_full_valid", 32'(s_valid), 32'h1);
    step(1, 1, 1, 32'h2000);
    step(0, 1, 0, 32'h0);
    chk("seqB_flushed", 32'(s_valid), 32'h0);
    chk("seqB_req", 32'(s_req), 32'h1);
    chk("seqB_addr", s_addr, 32'h2000);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 32'h0);

    // Random traffic against the stream model.
    lat_min = 1; lat_max = 4; pops = 0;
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) == 0, ($urandom % 10) < 7, ($urandom % 32) == 0,
           $urandom & 32'h0000_FFFC);
    chk("random_progress", 32'(pops > 500), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
